// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, drives the ROM address and registers
// each fetched word with its PC into a valid/ready stage toward decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fault,
    output logic [31:0] fetch_count
);

    // One past the last valid byte address; 33 bits so large ROMs cannot overflow.
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;

    typedef enum logic {
        RUN,
        FAULT
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        handshake;
    logic        load_slot;
    logic        pc_oob;

    assign imem_addr = pc;
    assign handshake = out_valid & out_ready;
    assign load_slot = ~out_valid | out_ready;
    assign pc_oob    = {1'b0, pc} >= PC_LIMIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= 32'h0;
            out_pc      <= 32'h0;
            fault       <= 1'b0;
            fetch_count <= 32'h0;
        end else begin
            // An accepted word counts even if this edge also flushes or faults.
            if (handshake) begin
                fetch_count <= fetch_count + 32'd1;
            end
            case (state)
                RUN: begin
                    if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                        state     <= FAULT;
                        fault     <= 1'b1;
                        out_valid <= 1'b0;
                    end else if (redirect_valid) begin
                        pc        <= redirect_pc;
                        out_valid <= 1'b0;
                    end else if (load_slot && pc_oob) begin
                        state     <= FAULT;
                        fault     <= 1'b1;
                        out_valid <= 1'b0;
                    end else if (load_slot) begin
                        out_instr <= imem_instr;
                        out_pc    <= pc;
                        out_valid <= 1'b1;
                        pc        <= pc + 32'd4;
                    end
                end
                FAULT: begin
                    // Frozen until reset.
                    out_valid <= 1'b0;
                    fault     <= 1'b1;
                end
                default: begin
                    state <= FAULT;
                    fault <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table with per-edge expectations
// plus a scoreboard of expected {pc, instr} pairs for every presented word.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fault;
    logic [31:0] fetch_count;

    int n_vec;
    int n_bad;

    typedef struct {
        logic        rb;     // reset before applying this vector
        logic        rdv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic        ef;
        logic [31:0] ecnt;
        logic [31:0] eaddr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    vec_t vq[$];
    sb_t  sbq[$];

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_WORDS(64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .fault         (fault),
        .fetch_count   (fetch_count)
    );

    // 64-word ROM model; out-of-range reads return a marker.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [29:0] idx;
        idx = a[31:2];
        if (idx >= 30'd64) return 32'hDEAD_BEEF;
        case (idx)
            30'd0:   return 32'h0020_81B3;
            30'd1:   return 32'h4020_81B3;
            30'd2:   return 32'h0052_F333;
            default: return 32'hA500_0013 | (32'(idx) << 8);
        endcase
    endfunction

    assign imem_instr = rom_word(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_instr", out_instr, 32'h0);
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        sbq.delete();
        check_reset_values();
    endtask

    // Compare DUT against scoreboard head if a word is expected this cycle.
    task automatic sb_check();
        sb_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("sb_valid", 32'(out_valid), 32'd1);
            chk("sb_pc", out_pc, e.pc);
            chk("sb_instr", out_instr, e.instr);
        end
    endtask

    task automatic apply(input vec_t v, input int i);
        sb_t e;
        redirect_valid = v.rdv;
        redirect_pc    = v.rpc;
        out_ready      = v.rdy;
        if (v.ev) begin
            e.pc    = v.epc;
            e.instr = rom_word(v.epc);
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(v.ev));
        chk($sformatf("v%0d_out_pc", i), out_pc, v.epc);
        chk($sformatf("v%0d_fault", i), 32'(fault), 32'(v.ef));
        chk($sformatf("v%0d_count", i), fetch_count, v.ecnt);
        chk($sformatf("v%0d_addr", i), imem_addr, v.eaddr);
        sb_check();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        rst = 1'b0;
        #1;

        //            rb    rdv   rpc           rdy   ev    epc           ef    cnt    addr
        // stream, stall at out_pc=4, release
        vq.push_back('{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h00, 1'b0, 32'd0, 32'h04});
        vq.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h04, 1'b0, 32'd1, 32'h08});
        vq.push_back('{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h04, 1'b0, 32'd1, 32'h08});
        vq.push_back('{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h04, 1'b0, 32'd1, 32'h08});
        vq.push_back('{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h04, 1'b0, 32'd1, 32'h08});
        vq.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h08, 1'b0, 32'd2, 32'h0C});
        vq.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h0C, 1'b0, 32'd3, 32'h10});
        // redirect coinciding with a handshake, then bubble-free target
        vq.push_back('{1'b0, 1'b1, 32'h14, 1'b1, 1'b0, 32'h0C, 1'b0, 32'd4, 32'h14});
        vq.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h14, 1'b0, 32'd4, 32'h18});
        // redirect during a stall drops the held word uncounted
        vq.push_back('{1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 32'h14, 1'b0, 32'd4, 32'h20});
        vq.push_back('{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h20, 1'b0, 32'd4, 32'h24});
        // last ROM word, then range fault on the next load slot
        vq.push_back('{1'b0, 1'b1, 32'hFC, 1'b1, 1'b0, 32'h20, 1'b0, 32'd5, 32'hFC});
        vq.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'hFC, 1'b0, 32'd5, 32'h100});
        vq.push_back('{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'hFC, 1'b1, 32'd6, 32'h100});
        vq.push_back('{1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 32'hFC, 1'b1, 32'd6, 32'h100});
        // misaligned redirect faults; later inputs are ignored
        vq.push_back('{1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 32'h00, 1'b0, 32'd0, 32'h04});
        vq.push_back('{1'b0, 1'b1, 32'h0A, 1'b1, 1'b0, 32'h00, 1'b1, 32'd1, 32'h04});
        vq.push_back('{1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h00, 1'b1, 32'd1, 32'h04});
        vq.push_back('{1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b1, 32'd1, 32'h04});

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rb) do_reset();
            apply(vq[i], i);
        end

        // Asynchronous reset in the middle of a stall, checked before the next edge.
        do_reset();
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_pc", out_pc, 32'h04);
        chk("stall_count", fetch_count, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_count", fetch_count, 32'd0);
        chk("async_addr", imem_addr, 32'h0);
        chk("async_out_pc", out_pc, 32'h0);
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_pc", out_pc, 32'h0);
        chk("post_rst_instr", out_instr, 32'h0020_81B3);
        chk("post_rst_count", fetch_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
